// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single-port memory with variable-latency ack.
// Optional watchdog abort with err output is enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                err
`endif
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SERVE_IF = 2'd1;
  localparam logic [1:0] ST_SERVE_LS = 2'd2;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WD_W     = $clog2(TIMEOUT + 1);
  localparam int unsigned PAT_REPS = (DATA_W + 31) / 32;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'({PAT_REPS{32'hDEAD_BEEF}});
`endif

  logic [1:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              if_gnt_q,    if_gnt_d;
  logic              if_valid_q,  if_valid_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic              ls_gnt_q,    ls_gnt_d;
  logic              ls_valid_q,  ls_valid_d;
  logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q,    mem_be_d;
  logic              busy_q,      busy_d;
  logic              cnt_below_max;
`ifdef ARB_TIMEOUT_EN
  logic [WD_W-1:0]   wd_q,        wd_d;
  logic              err_q,       err_d;
  logic              wd_expired;
`endif

  assign cnt_below_max = (cnt_q < CNT_W'(MAX_WAIT));
`ifdef ARB_TIMEOUT_EN
  assign wd_expired    = (wd_q == WD_W'(TIMEOUT - 1));
`endif

  // Next-state, grant decision and response capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    if_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_gnt_d    = 1'b0;
    ls_valid_d  = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
`ifdef ARB_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ls_req && (!if_req || cnt_below_max)) begin
          state_d     = ST_SERVE_LS;
          ls_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          mem_be_d    = ls_be;
          // Only reachable with if_req high while below MAX_WAIT, so this saturates
          if (if_req) cnt_d = cnt_q + CNT_W'(1);
`ifdef ARB_TIMEOUT_EN
          wd_d        = '0;
`endif
        end else if (if_req) begin
          state_d     = ST_SERVE_IF;
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          cnt_d       = '0;
`ifdef ARB_TIMEOUT_EN
          wd_d        = '0;
`endif
        end
      end

      ST_SERVE_IF: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_expired) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = TIMEOUT_DATA;
          err_d      = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end

      ST_SERVE_LS: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          ls_valid_d = 1'b1;
          ls_rdata_d = mem_we_q ? '0 : mem_rdata;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_expired) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          ls_valid_d = 1'b1;
          ls_rdata_d = TIMEOUT_DATA;
          err_d      = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      ls_gnt_q    <= 1'b0;
      ls_valid_q  <= 1'b0;
      ls_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if_gnt_q    <= if_gnt_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      ls_gnt_q    <= ls_gnt_d;
      ls_valid_q  <= ls_valid_d;
      ls_rdata_q  <= ls_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      busy_q      <= busy_d;
`ifdef ARB_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_gnt    = ls_gnt_q;
  assign ls_valid  = ls_valid_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected grant/valid events,
// a negedge monitor pops and compares them when the DUT pulses.
module tb_mem_arbiter;

  localparam int K_IFG = 0;
  localparam int K_LSG = 1;
  localparam int K_IFV = 2;
  localparam int K_LSV = 3;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_gnt;
  logic        ls_valid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef ARB_TIMEOUT_EN
  logic        err;
`endif

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_be     (ls_be),
    .ls_gnt    (ls_gnt),
    .ls_valid  (ls_valid),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int          n_total  = 0;
  int          n_passed = 0;
  int          cyc      = 0;
  int          ack_delay;
  int          wait_cnt;
  logic        spur;
  logic [31:0] rdata_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    else n_passed++;
  endfunction

  function automatic void push_gnt(input int kind, input int c, input logic [31:0] a,
                                   input logic w, input logic [3:0] b, input logic [31:0] wd);
    exp_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.we = w; e.be = b; e.wdata = wd;
    e.rdata = '0; e.err = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_val(input int kind, input int c, input logic [31:0] rd, input logic er);
    exp_t e;
    e.kind = kind; e.cyc = c; e.addr = '0; e.we = 1'b0; e.be = '0; e.wdata = '0;
    e.rdata = rd; e.err = er;
    exp_q.push_back(e);
  endfunction

  function automatic void mon(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_pulse_kind", 32'(kind), 32'hFFFF_FFFF);
      return;
    end
    e = exp_q.pop_front();
    chk("pulse_kind", 32'(kind), 32'(e.kind));
    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
    if (kind == K_IFG || kind == K_LSG) begin
      chk("gnt_mem_req", 32'(mem_req), 32'h1);
      chk("gnt_mem_addr", mem_addr, e.addr);
      chk("gnt_mem_we", 32'(mem_we), 32'(e.we));
      chk("gnt_mem_be", 32'(mem_be), 32'(e.be));
      if (kind == K_LSG) chk("gnt_mem_wdata", mem_wdata, e.wdata);
    end else begin
      chk("valid_rdata", (kind == K_IFV) ? if_rdata : ls_rdata, e.rdata);
`ifdef ARB_TIMEOUT_EN
      chk("valid_err", 32'(err), 32'(e.err));
`endif
    end
  endfunction

  // Monitor: outputs are registered, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (if_gnt)   mon(K_IFG);
      if (ls_gnt)   mon(K_LSG);
      if (if_valid) mon(K_IFV);
      if (ls_valid) mon(K_LSV);
    end
  end

  // Memory model: ack after ack_delay cycles of mem_req; spur forces ack regardless
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      if (spur) begin
        mem_ack = 1'b1;
      end else if (mem_req) begin
        mem_ack = (wait_cnt == ack_delay);
        wait_cnt++;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
      mem_rdata = rdata_val;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_if_gnt"},    32'(if_gnt),    32'h0);
    chk({tag, "_if_valid"},  32'(if_valid),  32'h0);
    chk({tag, "_if_rdata"},  if_rdata,       32'h0);
    chk({tag, "_ls_gnt"},    32'(ls_gnt),    32'h0);
    chk({tag, "_ls_valid"},  32'(ls_valid),  32'h0);
    chk({tag, "_ls_rdata"},  ls_rdata,       32'h0);
    chk({tag, "_mem_req"},   32'(mem_req),   32'h0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'h0);
    chk({tag, "_mem_addr"},  mem_addr,       32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'h0);
    chk({tag, "_mem_be"},    32'(mem_be),    32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
  endtask

  initial begin
    int c0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    spur = 1'b0; ack_delay = 0; rdata_val = '0;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, ack in the grant cycle
    c0 = cyc; rdata_val = 32'h0050_0093; ack_delay = 0;
    if_addr = 32'h100; if_req = 1'b1;
    push_gnt(K_IFG, c0 + 1, 32'h100, 1'b0, 4'hF, 32'h0);
    push_val(K_IFV, c0 + 2, 32'h0050_0093, 1'b0);
    @(negedge clk);
    if_req = 1'b0;
    chk("t1_busy_serve", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t1_busy_idle", 32'(busy), 32'h0);
    chk("t1_mem_req_drop", 32'(mem_req), 32'h0);
    repeat (2) @(negedge clk);

    // Stray ack while idle must not produce anything
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spur_busy", 32'(busy), 32'h0);
      chk("spur_mem_req", 32'(mem_req), 32'h0);
    end
    spur = 1'b0;
    repeat (2) @(negedge clk);

    // Store with ack 3 cycles late; inputs scrambled after grant
    c0 = cyc; rdata_val = 32'h1234_5678; ack_delay = 3;
    ls_we = 1'b1; ls_addr = 32'h2000; ls_wdata = 32'hCAFE_BABE; ls_be = 4'b0011; ls_req = 1'b1;
    push_gnt(K_LSG, c0 + 1, 32'h2000, 1'b1, 4'b0011, 32'hCAFE_BABE);
    push_val(K_LSV, c0 + 5, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        ls_req = 1'b0; ls_addr = 32'hDEAD_0000; ls_wdata = '0; ls_we = 1'b0; ls_be = 4'hF;
      end
      chk("t2_mem_req_hold", 32'(mem_req), 32'h1);
      chk("t2_mem_addr_hold", mem_addr, 32'h2000);
      chk("t2_mem_wdata_hold", mem_wdata, 32'hCAFE_BABE);
    end
    @(negedge clk);
    chk("t2_mem_req_drop", 32'(mem_req), 32'h0);
    repeat (2) @(negedge clk);

    // Contention: both held, expect LS x4, IF, LS x4, IF
    c0 = cyc; rdata_val = 32'h1111_2222; ack_delay = 0;
    ls_we = 1'b0; ls_addr = 32'h800; ls_be = 4'hF; ls_wdata = 32'h0; if_addr = 32'h400;
    if_req = 1'b1; ls_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        push_gnt(K_IFG, c0 + 1 + 2 * k, 32'h400, 1'b0, 4'hF, 32'h0);
        push_val(K_IFV, c0 + 2 + 2 * k, 32'h1111_2222, 1'b0);
      end else begin
        push_gnt(K_LSG, c0 + 1 + 2 * k, 32'h800, 1'b0, 4'hF, 32'h0);
        push_val(K_LSV, c0 + 2 + 2 * k, 32'h1111_2222, 1'b0);
      end
    end
    repeat (19) @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during a load; pending fetch granted afterwards
    c0 = cyc; ack_delay = 100; rdata_val = 32'h0BAD_F00D;
    ls_we = 1'b0; ls_addr = 32'h3000; ls_req = 1'b1;
    push_gnt(K_LSG, c0 + 1, 32'h3000, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    ls_req = 1'b0; if_addr = 32'h500; if_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("t4_rst");
    rst = 1'b0; ack_delay = 0;
    push_gnt(K_IFG, c0 + 4, 32'h500, 1'b0, 4'hF, 32'h0);
    push_val(K_IFV, c0 + 5, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    if_req = 1'b0;
    repeat (3) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // Watchdog abort, then ack landing in the last allowed cycle
    c0 = cyc; ack_delay = 1000; if_addr = 32'h600; if_req = 1'b1;
    push_gnt(K_IFG, c0 + 1, 32'h600, 1'b0, 4'hF, 32'h0);
    push_val(K_IFV, c0 + 17, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    if_req = 1'b0;
    repeat (16) @(negedge clk);
    chk("t5_busy_after_abort", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);

    c0 = cyc; ack_delay = 15; rdata_val = 32'h7777_8888; if_req = 1'b1;
    push_gnt(K_IFG, c0 + 1, 32'h600, 1'b0, 4'hF, 32'h0);
    push_val(K_IFV, c0 + 17, 32'h7777_8888, 1'b0);
    @(negedge clk);
    if_req = 1'b0;
    repeat (18) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    chk("events_outstanding", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port unified memory between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the fetch/data-access paths and the memory. Lets the core run from one memory with variable-latency acknowledge.
- Three-state FSM, fixed LS priority, starvation guard for IF, registered response capture.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_WAIT, 4, consecutive LS grants made while if_req is pending before IF is forced ahead.
- TIMEOUT, 16, cycles in a serve state without mem_ack before abort. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: IF request accepted.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  data address.
- ls_wdata  in  DATA_W  store data.
- ls_be  in  DATA_W/8  byte enables.
- ls_gnt  out  1  one-cycle pulse: LS request accepted.
- ls_valid  out  1  one-cycle pulse: LS done; ls_rdata valid for loads.
- ls_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  latched attributes of the active transaction.
- mem_ack  in  1  memory done; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: FSM = IDLE and starvation counter = 0. Every output is 0, including all gnt/valid pulses, mem_req, mem attributes and rdata registers.
- rst during SERVE abandons the transaction: mem_req drops in the next cycle and no valid pulse is produced. The memory must tolerate a dropped request.
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- States: IDLE, SERVE_IF, SERVE_LS.
- IDLE grant decision (all outputs registered; the decision is made in the cycle requests are sampled):
  - ls_req && (!if_req || cnt < MAX_WAIT) -> SERVE_LS, ls_gnt = 1 next cycle.
  - else if_req -> SERVE_IF, if_gnt = 1 next cycle.
  - else stay in IDLE.
- Starvation counter:
  - Increments, saturating at MAX_WAIT, on each LS grant made while if_req = 1.
  - Clears on any IF grant.
  - Unchanged otherwise.
- On a grant, the requester's attributes are latched into the mem_* registers. mem_req = 1 from the grant cycle (the cycle gnt is high) until the mem_ack cycle inclusive. For IF grants mem_we = 0 and mem_be = all ones.
- The requester may change or drop req/addr from the cycle after it sees gnt. The arbiter never re-samples the requester during SERVE.
- On mem_ack in SERVE_x:
  - mem_rdata is captured into x_rdata.
  - x_valid = 1 in the next cycle for exactly one cycle.
  - FSM returns to IDLE in that same cycle.
  - For stores, x_rdata is captured as 0.
- The cycle in which valid is high is an IDLE cycle, so a new grant decision is made in it.
- Minimum latency (req high at cycle 0, mem_ack at the first opportunity):
  - gnt and mem_req at cycle 1.
  - mem_ack at cycle 1, valid at cycle 2.
  - Next grant pulse at cycle 3.
- x_rdata holds its value until the next capture for the same requester.
- mem_ack is ignored in IDLE.
- Simultaneous if_req and ls_req follow the priority rule above. A requester never receives gnt while the other is being served.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Adds output port err (1 bit) and a watchdog counter, cleared on each grant.
  - If a serve state reaches TIMEOUT cycles without mem_ack: mem_req drops, the served requester gets x_valid = 1 with x_rdata = 32'hDEAD_BEEF (truncated/replicated to DATA_W), err = 1 in the same cycle as that valid, and FSM -> IDLE.
  - A mem_ack arriving in the timeout cycle takes precedence: normal completion, err = 0.
- Undefined: no err port and no watchdog; the arbiter waits indefinitely for mem_ack.

Test Plan:
- Single IF: if_req=1 with if_addr=0x100, memory acks in the gnt cycle with rdata 0x00500093 -> if_gnt at cycle 1, mem_addr=0x100, if_valid at cycle 2 with if_rdata=0x00500093, busy low at cycle 2.
- Store: ls_req=1, ls_we=1, ls_addr=0x2000, ls_wdata=0xCAFEBABE, ls_be=0011, ack delayed 3 cycles -> mem_req high for 4 cycles with the latched attributes, ls_valid one cycle later, ls_rdata=0.
- Contention: if_req and ls_req held high continuously, 1-cycle acks -> grant order LS, LS, LS, LS, IF, then LS again (MAX_WAIT=4). The counter clears after the IF grant.
- Reset mid-transaction: rst asserted during SERVE_LS before mem_ack -> next cycle mem_req=0, all outputs 0, no ls_valid. After rst drops, a pending if_req is granted normally.
- With ARB_TIMEOUT_EN: mem_ack never asserted, TIMEOUT=16 -> after 16 SERVE cycles err=1, if_valid=1, if_rdata=0xDEADBEEF, FSM back in IDLE. A repeat run with mem_ack in cycle 16 -> err=0.
